// File: rtl/grid_plotter.sv
// grid_plotter: snapshots the playfield bitmap on start, then walks it
// column by column, emitting one CELL x CELL block of pixels per grid cell
// to the VGA adapter. All outputs are registered.
module grid_plotter #(
  parameter int         GRID_W = 16,
  parameter int         GRID_H = 32,
  parameter int         CELL   = 3,
  parameter int         X_OFF  = 56,
  parameter int         Y_OFF  = 12,
  parameter logic [2:0] FG     = 3'b010,
  parameter logic [2:0] BG     = 3'b001
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     pause,
  input  logic [GRID_W*GRID_H-1:0] grid,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int PIX_W = 2;  // CELL never exceeds 3
  localparam int IDX_W = (GRID_W * GRID_H > 1) ? $clog2(GRID_W * GRID_H) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]               state;
  logic [GRID_W*GRID_H-1:0] snapshot;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [PIX_W-1:0]         px;
  logic [PIX_W-1:0]         py;
  // Set once the final pixel is out; the following edge enters DONE so the
  // done pulse lines up with the cycle in which a back-to-back start is taken.
  logic                     walk_end;

  logic [IDX_W-1:0] cell_idx;
  logic [7:0]       pix_x;
  logic [6:0]       pix_y;
  logic             px_last;
  logic             py_last;
  logic             row_last;
  logic             col_last;

  assign cell_idx = IDX_W'(col) * IDX_W'(GRID_H) + IDX_W'(row);
  assign pix_x    = 8'(X_OFF) + 8'(col) * 8'(CELL) + 8'(px);
  assign pix_y    = 7'(Y_OFF) + 7'(row) * 7'(CELL) + 7'(py);
  assign px_last  = (px == PIX_W'(CELL - 1));
  assign py_last  = (py == PIX_W'(CELL - 1));
  assign row_last = (row == ROW_W'(GRID_H - 1));
  assign col_last = (col == COL_W'(GRID_W - 1));

  // Control FSM, walk counters, snapshot and registered pixel outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      snapshot <= '0;
      col      <= '0;
      row      <= '0;
      px       <= '0;
      py       <= '0;
      walk_end <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          plot <= 1'b0;
          if (start) begin
            snapshot <= grid;
            col      <= '0;
            row      <= '0;
            px       <= '0;
            py       <= '0;
            walk_end <= 1'b0;
            busy     <= 1'b1;
            state    <= DRAW;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DRAW: begin
          if (walk_end) begin
            walk_end <= 1'b0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (pause) begin
            plot <= 1'b0;
          end else begin
            x      <= pix_x;
            y      <= pix_y;
            colour <= snapshot[cell_idx] ? FG : BG;
            plot   <= 1'b1;
            // px innermost, then py, row, col; each wraps and carries outward.
            if (px_last) begin
              px <= '0;
              if (py_last) begin
                py <= '0;
                if (row_last) begin
                  row <= '0;
                  if (col_last) begin
                    col      <= '0;
                    walk_end <= 1'b1;
                  end else begin
                    col <= col + 1'b1;
                  end
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                py <= py + 1'b1;
              end
            end else begin
              px <= px + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_plotter.sv
// Directed bench for grid_plotter at default parameters (16x32 grid,
// 3x3 cells, offset 56/12). A small walk model predicts every plotted pixel.
`timescale 1ns/1ps
module tb_grid_plotter;

  logic         clock;
  logic         resetn;
  logic         start;
  logic         pause;
  logic [511:0] grid;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [511:0] snap;
  int plots, fg, seq_err, gaps, fx, fy, lx, ly, lcol, done_busy, done_plot;
  bit saw_done;
  int bad_after;

  grid_plotter dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .pause  (pause),
    .grid   (grid),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start across one rising edge and check the E0 response.
  task automatic kick(input string tag);
    @(negedge clock);
    start = 1'b1;
    snap  = grid;
    @(negedge clock);
    start = 1'b0;
    check_val({tag, "_e0_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_e0_plot"}, 32'(plot), 32'd0);
  endtask

  // Observe one redraw from the cycle after E0 until the done pulse.
  task automatic watch(input logic [511:0] s, input int flip_at, input int start_at,
                       input int pause_at, input int pause_len, input bit restart);
    int col, row, py, px, ex, ey, ec;
    bit started;
    col = 0; row = 0; py = 0; px = 0; started = 0;
    plots = 0; fg = 0; seq_err = 0; gaps = 0;
    fx = -1; fy = -1; lx = -1; ly = -1; lcol = -1;
    saw_done = 0; done_busy = -1; done_plot = -1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      if (i == flip_at) grid = '1;
      if (i == start_at) start = 1'b1;
      if (i == start_at + 1) start = 1'b0;
      if (i == pause_at) pause = 1'b1;
      if (i == pause_at + pause_len) pause = 1'b0;
      if (done) begin
        saw_done  = 1;
        done_busy = int'(busy);
        done_plot = int'(plot);
        if (restart) begin
          start = 1'b1;
          snap  = grid;
        end
        break;
      end
      if (plot) begin
        ex = 56 + col * 3 + px;
        ey = 12 + row * 3 + py;
        ec = s[32 * col + row] ? 2 : 1;
        if (int'(x) != ex || int'(y) != ey || int'(colour) != ec) seq_err++;
        if (plots == 0) begin
          fx = int'(x);
          fy = int'(y);
        end
        lx = int'(x);
        ly = int'(y);
        lcol = int'(colour);
        if (colour == 3'b010) fg++;
        plots++;
        started = 1;
        if (px == 2) begin
          px = 0;
          if (py == 2) begin
            py = 0;
            if (row == 31) begin
              row = 0;
              col = (col == 15) ? 0 : col + 1;
            end else row++;
          end else py++;
        end else px++;
      end else if (started) begin
        gaps++;
      end
    end
  endtask

  task automatic frame_checks(input string t, input int exp_fg, input int exp_gaps);
    check_val({t, "_done_seen"}, 32'(saw_done), 32'd1);
    check_val({t, "_plots"}, 32'(plots), 32'd4608);
    check_val({t, "_first_x"}, 32'(fx), 32'd56);
    check_val({t, "_first_y"}, 32'(fy), 32'd12);
    check_val({t, "_last_x"}, 32'(lx), 32'd103);
    check_val({t, "_last_y"}, 32'(ly), 32'd107);
    check_val({t, "_fg_count"}, 32'(fg), 32'(exp_fg));
    check_val({t, "_seq_err"}, 32'(seq_err), 32'd0);
    check_val({t, "_gaps"}, 32'(gaps), 32'(exp_gaps));
    check_val({t, "_done_busy"}, 32'(done_busy), 32'd0);
    check_val({t, "_done_plot"}, 32'(done_plot), 32'd0);
    $display("frame %s: plots=%0d fg=%0d gaps=%0d last=(%0d,%0d)", t, plots, fg, gaps, lx, ly);
  endtask

  // Done must be a single cycle, followed by IDLE.
  task automatic after_done(input string t);
    @(negedge clock);
    check_val({t, "_done_len"}, 32'(done), 32'd0);
    check_val({t, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    grid   = '0;
    snap   = '0;
    repeat (3) @(negedge clock);
    check_val("rst_x", 32'(x), 32'd0);
    check_val("rst_y", 32'(y), 32'd0);
    check_val("rst_colour", 32'(colour), 32'd0);
    check_val("rst_plot", 32'(plot), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // All-clear grid: every pixel BG.
    grid = '0;
    kick("zero");
    watch(snap, -1, -1, -1, 0, 1'b0);
    frame_checks("zero", 0, 0);
    after_done("zero");

    // Cell (0,0) only: first 9 pixels FG.
    grid = '0;
    grid[0] = 1'b1;
    kick("bit0");
    watch(snap, -1, -1, -1, 0, 1'b0);
    frame_checks("bit0", 9, 0);
    after_done("bit0");

    // Cell (15,31) only: last 9 pixels FG.
    grid = '0;
    grid[511] = 1'b1;
    kick("bitlast");
    watch(snap, -1, -1, -1, 0, 1'b0);
    frame_checks("bitlast", 9, 0);
    check_val("bitlast_last_colour", 32'(lcol), 32'd2);
    after_done("bitlast");

    // Grid flips to all ones after the snapshot; start during busy ignored.
    grid = '0;
    kick("snapiso");
    watch(snap, 0, 100, -1, 0, 1'b0);
    frame_checks("snapiso", 0, 0);
    after_done("snapiso");

    // Pattern frame with a 10-cycle pause, then back-to-back restart.
    grid = {16{32'hA5C3_0F96}};
    kick("pause");
    watch(snap, -1, -1, 2000, 10, 1'b1);
    frame_checks("pause", 16 * 9 * 16, 10);
    @(negedge clock);
    start = 1'b0;
    check_val("b2b_busy", 32'(busy), 32'd1);
    check_val("b2b_done", 32'(done), 32'd0);
    check_val("b2b_plot", 32'(plot), 32'd0);
    watch(snap, -1, -1, -1, 0, 1'b0);
    frame_checks("b2b", 16 * 9 * 16, 0);
    after_done("b2b");

    // Asynchronous reset mid-walk, off the clock edge.
    grid = '1;
    kick("areset");
    repeat (500) @(negedge clock);
    check_val("areset_plot_before", 32'(plot), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_val("areset_x", 32'(x), 32'd0);
    check_val("areset_y", 32'(y), 32'd0);
    check_val("areset_colour", 32'(colour), 32'd0);
    check_val("areset_plot", 32'(plot), 32'd0);
    check_val("areset_busy", 32'(busy), 32'd0);
    @(negedge clock);
    #3;
    resetn = 1'b1;
    bad_after = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy || plot || done) bad_after++;
    end
    check_val("areset_stays_idle", 32'(bad_after), 32'd0);
    $display("areset: idle cycles checked=10 bad=%0d", bad_after);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
